fb_draw_scheduler: RTL and testbench

FB_DRAW_SCHEDULER -- requirements
Module: fb_draw_scheduler

---
 rtl/fb_draw_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_fb_draw_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_draw_scheduler.sv
// fb_draw_scheduler: queues CPU plot/fill commands and streams
// framebuffer pixel writes, yielding to display reads.
module fb_draw_scheduler #(
   parameter int FIFO_DEPTH = 4,
   parameter int FB_W       = 160,
   parameter int FB_H       = 120
) (
   input  logic       CLK,
   input  logic       RESB,
   input  logic       WR_EN,
   input  logic [1:0] WR_ADDR,
   input  logic [7:0] WR_DATA,
   input  logic       RD_REQ,
   output logic       FB_WE,
   output logic [7:0] FB_X,
   output logic [7:0] FB_Y,
   output logic [2:0] FB_COLOR,
   output logic       BUSY,
   output logic       FULL,
   output logic       OVERFLOW
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;
   localparam logic [7:0] XMAX = 8'(FB_W - 1);
   localparam logic [7:0] YMAX = 8'(FB_H - 1);
   localparam logic [8:0] XLIM = 9'(FB_W);
   localparam logic [8:0] YLIM = 9'(FB_H);

   typedef struct packed {
      logic       op;
      logic [7:0] x;
      logic [7:0] y;
      logic [2:0] color;
   } cmd_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PLOT,
      S_FILL
   } state_t;

   state_t      state;
   state_t      state_nxt;
   cmd_t        mem [FIFO_DEPTH];
   cmd_t        head;
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        empty;
   logic        full;
   logic        push;
   logic        pop;
   logic        accept;
   logic [7:0]  stg_x;
   logic [7:0]  stg_y;
   logic [2:0]  stg_c;
   logic [7:0]  cur_x;
   logic [7:0]  cur_y;
   logic [2:0]  cur_c;
   logic [7:0]  cnt_x;
   logic [7:0]  cnt_y;
   logic        oob;
   logic        last_pix;
   logic        pix_we;
   logic [7:0]  pix_x;
   logic [7:0]  pix_y;

   assign head     = mem[rd_ptr[AW-1:0]];
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push     = WR_EN && (WR_ADDR == 2'd3);
   assign accept   = push && (!full || pop);
   assign oob      = ({1'b0, cur_x} >= XLIM) || ({1'b0, cur_y} >= YLIM);
   assign last_pix = (cnt_x == XMAX) && (cnt_y == YMAX);
   assign BUSY     = !empty || (state != S_IDLE);
   assign FULL     = full;

   // next state, FIFO pop and the pixel to write this edge
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      pix_we    = 1'b0;
      pix_x     = cur_x;
      pix_y     = cur_y;
      unique case (state)
         S_IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = head.op ? S_FILL : S_PLOT;
            end
         end
         S_PLOT: begin
            if (oob) begin
               state_nxt = S_IDLE;
            end else if (!RD_REQ) begin
               pix_we    = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_FILL: begin
            pix_x = cnt_x;
            pix_y = cnt_y;
            if (!RD_REQ) begin
               pix_we = 1'b1;
               if (last_pix) state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // FIFO pointers and sticky overflow flag
   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         OVERFLOW <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !accept) OVERFLOW <= 1'b1;
      end
   end

   // FIFO storage; emptiness is carried by the pointers alone
   always_ff @(posedge CLK) begin
      if (accept) begin
         mem[wr_ptr[AW-1:0]] <= '{op: WR_DATA[0], x: stg_x,
                                  y: stg_y, color: stg_c};
      end
   end

   // CPU staging registers
   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) begin
         stg_x <= '0;
         stg_y <= '0;
         stg_c <= '0;
      end else if (WR_EN) begin
         unique case (WR_ADDR)
            2'd0:    stg_x <= WR_DATA;
            2'd1:    stg_y <= WR_DATA;
            2'd2:    stg_c <= WR_DATA[2:0];
            default: ;
         endcase
      end
   end

   // executing command latched at pop; fill raster counters
   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) begin
         cur_x <= '0;
         cur_y <= '0;
         cur_c <= '0;
         cnt_x <= '0;
         cnt_y <= '0;
      end else if (pop) begin
         cur_x <= head.x;
         cur_y <= head.y;
         cur_c <= head.color;
         cnt_x <= '0;
         cnt_y <= '0;
      end else if (state == S_FILL && pix_we) begin
         if (cnt_x == XMAX) begin
            cnt_x <= '0;
            cnt_y <= cnt_y + 8'd1;
         end else begin
            cnt_x <= cnt_x + 8'd1;
         end
      end
   end

   // registered framebuffer write port; coordinates hold between writes
   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) begin
         FB_WE    <= 1'b0;
         FB_X     <= '0;
         FB_Y     <= '0;
         FB_COLOR <= '0;
      end else begin
         FB_WE <= pix_we;
         if (pix_we) begin
            FB_X     <= pix_x;
            FB_Y     <= pix_y;
            FB_COLOR <= cur_c;
         end
      end
   end

endmodule

// File: tb/tb_fb_draw_scheduler.sv
// tb_fb_draw_scheduler: scoreboard bench, expected pixel stream
// built from command semantics, checked by a write monitor.
module tb_fb_draw_scheduler;

   logic       CLK = 1'b0;
   logic       RESB = 1'b0;
   logic       WR_EN = 1'b0;
   logic [1:0] WR_ADDR = '0;
   logic [7:0] WR_DATA = '0;
   logic       RD_REQ = 1'b0;
   logic       FB_WE;
   logic [7:0] FB_X;
   logic [7:0] FB_Y;
   logic [2:0] FB_COLOR;
   logic       BUSY;
   logic       FULL;
   logic       OVERFLOW;

   int          n_chk = 0;
   int          n_pass = 0;
   int          we_seen = 0;
   logic [18:0] exp_q[$];
   bit          rd_mode = 1'b0;
   bit          rd_force = 1'b0;
   int          rd_pct = 50;
   bit          rd_at_edge = 1'b0;

   fb_draw_scheduler #(
      .FIFO_DEPTH(4),
      .FB_W(160),
      .FB_H(120)
   ) dut (
      .CLK(CLK),
      .RESB(RESB),
      .WR_EN(WR_EN),
      .WR_ADDR(WR_ADDR),
      .WR_DATA(WR_DATA),
      .RD_REQ(RD_REQ),
      .FB_WE(FB_WE),
      .FB_X(FB_X),
      .FB_Y(FB_Y),
      .FB_COLOR(FB_COLOR),
      .BUSY(BUSY),
      .FULL(FULL),
      .OVERFLOW(OVERFLOW)
   );

   always #5 CLK = ~CLK;

   function automatic logic [18:0] pix(input int x, input int y, input int c);
      return {8'(x), 8'(y), 3'(c)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, req);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      WR_EN = 1'b1;
      WR_ADDR = a;
      WR_DATA = d;
      tick();
      WR_EN = 1'b0;
   endtask

   // PLOT command; only on-screen coordinates produce an expected write
   task automatic plot(input int x, input int y, input int c);
      wr(2'd0, 8'(x));
      wr(2'd1, 8'(y));
      wr(2'd2, 8'(c));
      if (x < 160 && y < 120) exp_q.push_back(pix(x, y, c));
      wr(2'd3, 8'd0);
   endtask

   task automatic expect_fill(input int c);
      for (int y = 0; y < 120; y++)
         for (int x = 0; x < 160; x++)
            exp_q.push_back(pix(x, y, c));
   endtask

   task automatic wait_idle(input string name, input int limit);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (!BUSY && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk(name, 32'(ok), 32'd1);
      exp_q.delete();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_we"}, 32'(FB_WE), 32'd0);
      chk({tag, "_x"}, 32'(FB_X), 32'd0);
      chk({tag, "_y"}, 32'(FB_Y), 32'd0);
      chk({tag, "_color"}, 32'(FB_COLOR), 32'd0);
      chk({tag, "_busy"}, 32'(BUSY), 32'd0);
      chk({tag, "_full"}, 32'(FULL), 32'd0);
      chk({tag, "_overflow"}, 32'(OVERFLOW), 32'd0);
   endtask

   // display read request generator
   initial begin
      forever begin
         @(posedge CLK);
         #2;
         if (rd_mode) RD_REQ = ($urandom_range(0, 99) < rd_pct);
         else         RD_REQ = rd_force;
      end
   end

   // RD_REQ as seen by the DUT on each rising edge
   initial begin
      forever begin
         @(posedge CLK);
         rd_at_edge = RD_REQ;
      end
   end

   // write monitor: every FB_WE pulse must match the scoreboard head
   initial begin
      logic [18:0] e;
      forever begin
         @(negedge CLK);
         if (RESB && FB_WE) begin
            we_seen++;
            chk("we_during_rd", 32'(rd_at_edge), 32'd0);
            n_chk++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_write actual=(%0d,%0d,%0d) required=none",
                        FB_X, FB_Y, FB_COLOR);
            end else begin
               e = exp_q.pop_front();
               if ({FB_X, FB_Y, FB_COLOR} === e) n_pass++;
               else $display("FAIL pixel actual=(%0d,%0d,%0d) required=(%0d,%0d,%0d)",
                             FB_X, FB_Y, FB_COLOR, e[18:11], e[10:3], e[2:0]);
            end
         end
      end
   end

   initial begin
      int base;
      bit found;

      repeat (2) @(posedge CLK);
      #1;
      chk_reset_outputs("reset");
      RESB = 1'b1;
      tick();

      // single plot, latency and hold
      wr(2'd0, 8'd10);
      wr(2'd1, 8'd20);
      wr(2'd2, 8'd5);
      exp_q.push_back(pix(10, 20, 5));
      wr(2'd3, 8'd0);
      @(negedge CLK);
      chk("lat_edge0", 32'(FB_WE), 32'd0);
      @(negedge CLK);
      chk("lat_edge1", 32'(FB_WE), 32'd0);
      @(negedge CLK);
      chk("lat_edge2", 32'(FB_WE), 32'd1);
      chk("busy_fall", 32'(BUSY), 32'd0);
      repeat (3) tick();
      chk("hold_we", 32'(FB_WE), 32'd0);
      chk("hold_xyc", 32'({FB_X, FB_Y, FB_COLOR}), 32'(pix(10, 20, 5)));

      // plot stalled by display reads
      rd_force = 1'b1;
      tick();
      plot(33, 44, 2);
      for (int i = 0; i < 7; i++) begin
         @(negedge CLK);
         chk("stall_no_we", 32'(FB_WE), 32'd0);
      end
      tick();
      rd_force = 1'b0;
      wait_idle("stall_drain", 50);

      // off-screen plot is skipped, corner plot is written
      base = we_seen;
      plot(160, 0, 7);
      plot(159, 119, 4);
      wait_idle("oob_drain", 50);
      chk("oob_write_count", 32'(we_seen - base), 32'd1);

      // random plot bursts from idle, random display reads
      rd_mode = 1'b1;
      rd_pct = 30;
      for (int b = 0; b < 25; b++) begin
         int n;
         n = $urandom_range(1, 4);
         for (int k = 0; k < n; k++)
            plot($urandom_range(0, 170), $urandom_range(0, 130),
                 $urandom_range(0, 7));
         wait_idle("burst_drain", 200);
      end
      chk("no_overflow_yet", 32'(OVERFLOW), 32'd0);

      // full-screen fill with staging writes during execution
      rd_pct = 50;
      base = we_seen;
      wr(2'd2, 8'd3);
      expect_fill(3);
      wr(2'd3, 8'd1);
      wr(2'd0, 8'd200);
      wr(2'd1, 8'd200);
      wr(2'd2, 8'd1);
      wait_idle("fill_drain", 60000);
      chk("fill_count", 32'(we_seen - base), 32'd19200);

      // overflow: one stalled plot, then five pushes into a depth-4 FIFO
      rd_mode = 1'b0;
      rd_force = 1'b1;
      tick();
      plot(1, 1, 1);
      tick();
      tick();
      for (int k = 0; k < 4; k++) begin
         wr(2'd0, 8'(10 + k));
         exp_q.push_back(pix(10 + k, 1, 1));
         wr(2'd3, 8'd0);
      end
      chk("full_set", 32'(FULL), 32'd1);
      chk("overflow_clear", 32'(OVERFLOW), 32'd0);
      wr(2'd0, 8'd20);
      wr(2'd3, 8'd0);
      chk("overflow_set", 32'(OVERFLOW), 32'd1);
      chk("full_hold", 32'(FULL), 32'd1);
      rd_force = 1'b0;
      wait_idle("overflow_drain", 100);
      chk("full_clear", 32'(FULL), 32'd0);
      chk("overflow_sticky", 32'(OVERFLOW), 32'd1);

      // reset in the middle of a fill with two commands queued
      rd_mode = 1'b1;
      rd_pct = 50;
      wr(2'd2, 8'd6);
      expect_fill(6);
      wr(2'd3, 8'd1);
      wr(2'd0, 8'd1);
      exp_q.push_back(pix(1, 1, 6));
      wr(2'd3, 8'd0);
      wr(2'd0, 8'd2);
      exp_q.push_back(pix(2, 1, 6));
      wr(2'd3, 8'd0);
      found = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge CLK);
         if (FB_WE && FB_X == 8'd40 && FB_Y == 8'd3) begin
            found = 1'b1;
            break;
         end
      end
      chk("reach_40_3", 32'(found), 32'd1);
      #1;
      RESB = 1'b0;
      #1;
      chk_reset_outputs("midfill");
      exp_q.delete();
      base = we_seen;
      repeat (3) @(posedge CLK);
      #3;
      RESB = 1'b1;
      repeat (200) tick();
      chk("no_write_after_reset", 32'(we_seen - base), 32'd0);
      chk("idle_after_reset", 32'(BUSY), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
